// File: rtl/usb_rx_bit_decoder_if.sv
// Line-side inputs and decoded-byte outputs of the USB receive bit decoder.
// The master modport is the decoder; the slave is the line driver / packet layer.
interface usb_rx_bit_decoder_if;
    logic       d_plus_sync;
    logic       d_minus_sync;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       rx_active;
    logic       eop;
    logic       stuff_err;

    modport master (
        input  d_plus_sync,
        input  d_minus_sync,
        output rx_data,
        output byte_valid,
        output rx_active,
        output eop,
        output stuff_err
    );

    modport slave (
        output d_plus_sync,
        output d_minus_sync,
        input  rx_data,
        input  byte_valid,
        input  rx_active,
        input  eop,
        input  stuff_err
    );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: bit-timing recovery from D+ edges, NRZI decode,
// stuffed-bit removal, LSB-first byte assembly, EOP and stuff-error strobes.
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    usb_rx_bit_decoder_if.master bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        ERROR    = 2'd2,
        EOP_WAIT = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    ones_cnt, ones_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          last_level, last_level_n;
    logic          dp_prev, dp_prev_n;
    logic [7:0]    rx_data_q, rx_data_n;
    logic          byte_valid_q, byte_valid_n;
    logic          eop_q, eop_n;
    logic          stuff_err_q, stuff_err_n;

    logic          dp, dm;
    logic          line_edge, sample, se0, se1, dec_bit;

    // NRZI: no transition means a 1, a transition means a 0.
    function automatic logic nrzi_bit(input logic level, input logic prev_level);
        return (level == prev_level);
    endfunction

    assign dp        = bus.d_plus_sync;
    assign dm        = bus.d_minus_sync;
    assign line_edge = (dp != dp_prev);
    assign sample    = (timer == '0) && !line_edge;
    assign se0       = !dp && !dm;
    assign se1       = dp && dm;
    assign dec_bit   = nrzi_bit(dp, last_level);

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        ones_n       = ones_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        last_level_n = last_level;
        dp_prev_n    = dp;
        rx_data_n    = rx_data_q;
        byte_valid_n = 1'b0;
        eop_n        = 1'b0;
        stuff_err_n  = 1'b0;

        if (state == RECEIVE || state == ERROR) begin
            if (line_edge)
                timer_n = TW'(HALF - 1);
            else if (timer == '0)
                timer_n = TW'(CLKS_PER_BIT - 1);
            else
                timer_n = timer - 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (dp_prev && !dp) begin
                    state_n      = RECEIVE;
                    timer_n      = TW'(HALF - 1);
                    ones_n       = '0;
                    bit_cnt_n    = '0;
                    shift_n      = '0;
                    last_level_n = 1'b1;
                end
            end
            RECEIVE: begin
                if (sample) begin
                    if (se0) begin
                        eop_n   = 1'b1;
                        state_n = EOP_WAIT;
                    end else if (se1) begin
                        stuff_err_n = 1'b1;
                        state_n     = ERROR;
                    end else begin
                        last_level_n = dp;
                        if (ones_cnt == 3'd6) begin
                            // After six 1s the transmitter must insert a 0; drop it.
                            if (dec_bit) begin
                                stuff_err_n = 1'b1;
                                state_n     = ERROR;
                            end else begin
                                ones_n = '0;
                            end
                        end else begin
                            shift_n   = {dec_bit, shift[7:1]};
                            ones_n    = dec_bit ? ones_cnt + 3'd1 : 3'd0;
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data_n    = {dec_bit, shift[7:1]};
                                byte_valid_n = 1'b1;
                            end
                        end
                    end
                end
            end
            ERROR: begin
                if (sample && se0) begin
                    eop_n   = 1'b1;
                    state_n = EOP_WAIT;
                end
            end
            EOP_WAIT: begin
                if (dp && !dm) begin
                    state_n   = IDLE;
                    dp_prev_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            last_level   <= 1'b1;
            dp_prev      <= 1'b1;
            rx_data_q    <= '0;
            byte_valid_q <= 1'b0;
            eop_q        <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            ones_cnt     <= ones_n;
            bit_cnt      <= bit_cnt_n;
            shift        <= shift_n;
            last_level   <= last_level_n;
            dp_prev      <= dp_prev_n;
            rx_data_q    <= rx_data_n;
            byte_valid_q <= byte_valid_n;
            eop_q        <= eop_n;
            stuff_err_q  <= stuff_err_n;
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.rx_active  = (state == RECEIVE) || (state == ERROR);
    assign bus.eop        = eop_q;
    assign bus.stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Bench for usb_rx_bit_decoder: directed symbol-stream table, randomized packets
// built by a stuffing/NRZI line model, and reset / timing corner sequences.
module tb_usb_rx_bit_decoder;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_rx_bit_decoder_if bus();

    usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    int bv_total = 0, eop_total = 0, serr_total = 0, overlap = 0, act_hi = 0;
    int act_rise_cyc = -1, last_bv_cyc = -1;
    logic act_prev = 1'b0;
    logic [7:0] got[$];
    logic level = 1'b1;

    // Symbols: '0'/'1' are already-stuffed data bits before NRZI, 'S' is an SE1 bit time.
    typedef struct {
        string      syms;
        int         exp_nb;
        logic [7:0] exp_last;
        int         exp_eop;
        int         exp_serr;
    } vec_t;
    vec_t vecs[8];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.byte_valid === 1'b1) begin
            got.push_back(bus.rx_data);
            bv_total++;
            last_bv_cyc = cyc;
        end
        if (bus.eop === 1'b1) eop_total++;
        if (bus.stuff_err === 1'b1) serr_total++;
        if (bus.eop === 1'b1 && bus.stuff_err === 1'b1) overlap++;
        if (bus.rx_active === 1'b1) act_hi++;
        if (bus.rx_active === 1'b1 && !act_prev) act_rise_cyc = cyc;
        act_prev = (bus.rx_active === 1'b1);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive_line(input logic dp, input logic dm, input int n);
        bus.d_plus_sync  = dp;
        bus.d_minus_sync = dm;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_syms(input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "S") begin
                drive_line(1'b1, 1'b1, CPB);
            end else begin
                if (s[i] == "0") level = ~level;
                drive_line(level, ~level, CPB);
            end
        end
    endtask

    task automatic send_packet(input string s);
        level     = 1'b1;
        start_cyc = cyc;
        send_syms(s);
        drive_line(1'b0, 1'b0, 2 * CPB);
        drive_line(1'b1, 1'b0, 3 * CPB);
        level = 1'b1;
    endtask

    // Line model: SYNC then LSB-first data, a 0 inserted after every six consecutive 1s.
    function automatic string gen_stream(input logic [7:0] d[$]);
        string s;
        int    ones;
        logic [7:0] b;
        s    = "";
        ones = 0;
        for (int k = 0; k <= d.size(); k++) begin
            b = (k == 0) ? 8'h80 : d[k-1];
            for (int j = 0; j < 8; j++) begin
                if (b[j]) begin
                    s = {s, "1"};
                    ones++;
                end else begin
                    s = {s, "0"};
                    ones = 0;
                end
                if (ones == 6) begin
                    s = {s, "0"};
                    ones = 0;
                end
            end
        end
        return s;
    endfunction

    initial begin
        int nb0, q0, e0, s0, a0, n, r;
        logic [7:0] data[$];
        logic [7:0] exp_q[$];

        vecs[0] = '{"00000001",                                  1, 8'h80, 1, 0};
        vecs[1] = '{"0000000111111011100000000",                 3, 8'h00, 1, 0};
        vecs[2] = '{"00000001111111",                            1, 8'h80, 1, 1};
        vecs[3] = '{"00000001101",                               1, 8'h80, 1, 0};
        vecs[4] = '{"0000000110S",                               1, 8'h80, 1, 1};
        vecs[5] = '{"0000000101010101",                          2, 8'hAA, 1, 0};
        vecs[6] = '{"00000001111110110",                         2, 8'h7F, 1, 0};
        vecs[7] = '{"0000000111111011111101111110",              3, 8'hFF, 1, 0};

        // Reset with the line at J
        rst = 1'b1;
        drive_line(1'b1, 1'b0, 2);
        check("reset rx_data", int'(bus.rx_data), 0);
        check("reset byte_valid", int'(bus.byte_valid), 0);
        check("reset rx_active", int'(bus.rx_active), 0);
        check("reset eop", int'(bus.eop), 0);
        check("reset stuff_err", int'(bus.stuff_err), 0);
        rst = 1'b0;
        a0 = act_hi;
        drive_line(1'b1, 1'b0, 100);
        check("idle rx_active cycles", act_hi - a0, 0);

        // SYNC timing
        nb0 = bv_total; q0 = got.size();
        send_packet("00000001");
        check("sync rx_active rise latency", act_rise_cyc - start_cyc, 1);
        check("sync byte_valid latency", last_bv_cyc - start_cyc, 61);
        check("sync byte count", bv_total - nb0, 1);
        check("sync rx_data", (got.size() > q0) ? int'(got[q0]) : -1, 8'h80);
        check("sync rx_active after eop", int'(bus.rx_active), 0);

        // Directed symbol streams
        for (int v = 0; v < 8; v++) begin
            nb0 = bv_total; e0 = eop_total; s0 = serr_total;
            send_packet(vecs[v].syms);
            check($sformatf("vec%0d byte count", v), bv_total - nb0, vecs[v].exp_nb);
            check($sformatf("vec%0d last byte", v),
                  (got.size() > 0) ? int'(got[got.size()-1]) : -1, int'(vecs[v].exp_last));
            check($sformatf("vec%0d eop pulses", v), eop_total - e0, vecs[v].exp_eop);
            check($sformatf("vec%0d stuff_err pulses", v), serr_total - s0, vecs[v].exp_serr);
            check($sformatf("vec%0d rx_active idle", v), int'(bus.rx_active), 0);
        end
        // Second byte of the FF/00 stream must be FF
        check("stuff FF byte", (got.size() > 2) ? int'(got[got.size()-12]) : -1, 8'hFF);

        // Randomized packets against the line model
        for (int p = 0; p < 25; p++) begin
            data.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 3);
                data.push_back((r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom));
            end
            exp_q = data;
            exp_q.push_front(8'h80);
            nb0 = bv_total; q0 = got.size(); e0 = eop_total; s0 = serr_total;
            send_packet(gen_stream(data));
            check($sformatf("rnd%0d byte count", p), bv_total - nb0, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("rnd%0d byte%0d", p, k),
                      (q0 + k < got.size()) ? int'(got[q0+k]) : -1, int'(exp_q[k]));
            check($sformatf("rnd%0d eop", p), eop_total - e0, 1);
            check($sformatf("rnd%0d stuff_err", p), serr_total - s0, 0);
        end

        // Reset mid-packet after 5 bits
        level = 1'b1;
        send_syms("00000");
        rst = 1'b1;
        drive_line(level, ~level, 1);
        check("midrst rx_data", int'(bus.rx_data), 0);
        check("midrst byte_valid", int'(bus.byte_valid), 0);
        check("midrst rx_active", int'(bus.rx_active), 0);
        check("midrst eop", int'(bus.eop), 0);
        check("midrst stuff_err", int'(bus.stuff_err), 0);
        rst = 1'b0;
        nb0 = bv_total;
        send_syms("001");
        drive_line(1'b1, 1'b0, 2 * CPB);
        check("midrst no byte from tail", bv_total - nb0, 0);
        drive_line(1'b0, 1'b0, 2 * CPB);
        drive_line(1'b1, 1'b0, 3 * CPB);
        nb0 = bv_total; q0 = got.size();
        send_packet("00000001");
        check("post-reset sync count", bv_total - nb0, 1);
        check("post-reset sync data", (got.size() > q0) ? int'(got[q0]) : -1, 8'h80);

        check("eop/stuff_err overlap cycles", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
